// File: rtl/axis_16bit_fifo.sv
// axis_16bit_fifo: synchronous first-word-fall-through FIFO that decouples the
// 8-bit adder's sum stream from receiver backpressure. The head word is
// presented combinationally from the storage array, so a word written at one
// edge is visible right after it and can be popped at the next edge.
module axis_16bit_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_axis_data,
    input  logic             s_axis_valid,
    output logic             s_axis_ready,
    output logic [WIDTH-1:0] m_axis_data,
    output logic             m_axis_valid,
    input  logic             m_axis_ready,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    // Flags decode registered occupancy only; ready/valid are additionally
    // forced low during reset so no handshake can complete in a reset cycle.
    // Neither ready nor valid looks at the opposite side's handshake input,
    // and a full FIFO refuses writes even when a pop happens the same cycle.
    always_comb begin
        full         = (level == FULL_LVL);
        empty        = (level == '0);
        s_axis_ready = !full && !rst;
        m_axis_valid = !empty && !rst;
        m_axis_data  = m_axis_valid ? mem[rd_ptr] : '0;
        push         = s_axis_valid && s_axis_ready;
        pop          = m_axis_valid && m_axis_ready;
    end

    // Storage write; contents are intentionally left alone on reset, the
    // pointers/level reset is what discards them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_axis_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two; level moves only
    // when exactly one of push/pop fires.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      level <= level + 1'b1;
            else if (pop && !push) level <= level - 1'b1;
        end
    end

endmodule

// File: tb/tb_axis_16bit_fifo.sv
// Directed bench for axis_16bit_fifo (DEPTH=4, WIDTH=16). Inputs change and
// outputs are sampled 1 time unit after the rising edge.
module tb_axis_16bit_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] s_axis_data;
    logic        s_axis_valid;
    logic        s_axis_ready;
    logic [15:0] m_axis_data;
    logic        m_axis_valid;
    logic        m_axis_ready;
    logic [2:0]  level;
    logic        full;
    logic        empty;

    int n_chk = 0;
    int n_err = 0;

    axis_16bit_fifo #(.DEPTH(4), .WIDTH(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_data  (s_axis_data),
        .s_axis_valid (s_axis_valid),
        .s_axis_ready (s_axis_ready),
        .m_axis_data  (m_axis_data),
        .m_axis_valid (m_axis_valid),
        .m_axis_ready (m_axis_ready),
        .level        (level),
        .full         (full),
        .empty        (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] exp5 [5];
        int wr_idx;
        int rd_idx;
        logic do_push;
        logic do_pop;

        rst = 1'b1; s_axis_data = '0; s_axis_valid = 1'b0; m_axis_ready = 1'b0;

        // Reset held for two edges.
        tick();
        chk("rst1_ready", s_axis_ready, 0);
        chk("rst1_valid", m_axis_valid, 0);
        chk("rst1_data",  m_axis_data,  0);
        tick();
        chk("rst2_ready", s_axis_ready, 0);
        chk("rst2_valid", m_axis_valid, 0);
        chk("rst2_level", level, 0);
        chk("rst2_empty", empty, 1);
        chk("rst2_full",  full, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", s_axis_ready, 1);
        chk("post_rst_valid", m_axis_valid, 0);
        chk("post_rst_level", level, 0);
        chk("post_rst_empty", empty, 1);

        // Fill with receiver stalled; 5th word must stay held upstream.
        tick();
        s_axis_valid = 1'b1;
        s_axis_data = 16'h0011; tick();
        chk("fill1_head", m_axis_data, 16'h0011);
        chk("fill1_valid", m_axis_valid, 1);
        s_axis_data = 16'h0022; tick();
        s_axis_data = 16'h0033; tick();
        s_axis_data = 16'h0044; tick();
        chk("fill4_level", level, 4);
        chk("fill4_full",  full, 1);
        chk("fill4_ready", s_axis_ready, 0);
        s_axis_data = 16'h0055; tick();
        chk("full_hold_level", level, 4);
        chk("full_hold_head",  m_axis_data, 16'h0011);
        chk("full_hold_ready", s_axis_ready, 0);

        // Drain from full; 0x0055 gets in once space opens.
        exp5[0] = 16'h0011; exp5[1] = 16'h0022; exp5[2] = 16'h0033;
        exp5[3] = 16'h0044; exp5[4] = 16'h0055;
        m_axis_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("drain_valid", m_axis_valid, 1);
            chk("drain_data", m_axis_data, exp5[i]);
            do_push = s_axis_valid && s_axis_ready;
            if (i == 0) chk("drain_full_no_push", s_axis_ready, 0);
            tick();
            if (do_push) s_axis_valid = 1'b0;
        end
        chk("drain_empty", empty, 1);
        chk("drain_level", level, 0);
        chk("drain_valid_low", m_axis_valid, 0);

        // Simultaneous push/pop at level 2.
        m_axis_ready = 1'b0;
        s_axis_valid = 1'b1;
        s_axis_data = 16'h00AA; tick();
        s_axis_data = 16'h00BB; tick();
        s_axis_valid = 1'b0;
        chk("mid_level2", level, 2);
        chk("mid_head_aa", m_axis_data, 16'h00AA);
        s_axis_valid = 1'b1; s_axis_data = 16'h00CC; m_axis_ready = 1'b1;
        tick();
        s_axis_valid = 1'b0; m_axis_ready = 1'b0;
        #1;
        chk("mid_level_hold", level, 2);
        chk("mid_head_bb", m_axis_data, 16'h00BB);
        m_axis_ready = 1'b1;
        tick();
        chk("mid_head_cc", m_axis_data, 16'h00CC);
        tick();
        chk("mid_empty", empty, 1);
        m_axis_ready = 1'b0;

        // Stream 10 words with random receiver stalls (pointers wrap).
        wr_idx = 0;
        rd_idx = 0;
        for (int cyc = 0; cyc < 300 && rd_idx < 10; cyc++) begin
            s_axis_valid = (wr_idx < 10);
            s_axis_data  = 16'(wr_idx);
            m_axis_ready = 1'($urandom_range(0, 1));
            #1;
            do_push = s_axis_valid && s_axis_ready;
            do_pop  = m_axis_valid && m_axis_ready;
            if (do_pop) chk("stream_data", m_axis_data, 16'(rd_idx));
            tick();
            if (do_push) wr_idx++;
            if (do_pop)  rd_idx++;
        end
        chk("stream_count", rd_idx, 10);
        s_axis_valid = 1'b0;
        m_axis_ready = 1'b0;
        #1;
        chk("stream_empty", empty, 1);

        // Push into empty FIFO with receiver ready: no pop that cycle.
        s_axis_valid = 1'b1; s_axis_data = 16'h1234; m_axis_ready = 1'b1;
        #1;
        chk("fwft_pre_valid", m_axis_valid, 0);
        tick();
        s_axis_valid = 1'b0;
        chk("fwft_level", level, 1);
        chk("fwft_valid", m_axis_valid, 1);
        chk("fwft_data", m_axis_data, 16'h1234);
        tick();
        chk("fwft_popped_level", level, 0);
        chk("fwft_popped_valid", m_axis_valid, 0);
        m_axis_ready = 1'b0;

        // Reset mid-operation at level 3 with receiver ready.
        s_axis_valid = 1'b1;
        s_axis_data = 16'h0101; tick();
        s_axis_data = 16'h0202; tick();
        s_axis_data = 16'h0303; tick();
        s_axis_valid = 1'b0;
        chk("rstmid_level3", level, 3);
        rst = 1'b1; m_axis_ready = 1'b1;
        #1;
        chk("rstmid_valid_forced", m_axis_valid, 0);
        chk("rstmid_data_forced", m_axis_data, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("rstmid_level", level, 0);
        chk("rstmid_valid", m_axis_valid, 0);
        chk("rstmid_empty", empty, 1);
        m_axis_ready = 1'b0;
        s_axis_valid = 1'b1; s_axis_data = 16'h0F0F;
        tick();
        s_axis_valid = 1'b0;
        chk("rstmid_new_head", m_axis_data, 16'h0F0F);
        chk("rstmid_new_level", level, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
